uart_rx_frame_ctrl: RTL

UART receive frame controller: detects the start bit on the raw serial line and generates the oversampling edge count and sample enable for `data_sampling`. It consumes `data_sampling`'s voted `sampled_bit` once per bit period and deserializes the data LSB-first. It also checks parity and stop bits and presents each accepted byte with a one-cycle valid strobe to the downstream register-file/ALU control path.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/edge_bit_counter.sv | 51 +++++
 rtl/uart_rx_frame_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// The top frame controller imports this package.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_X8  = 7;
    localparam int PRESCALE_X16 = 15;
    localparam int PRESCALE_X32 = 31;

    // The parity bit the transmitter should have sent, given the XOR of its data bits.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and received-bit counter for the UART RX frame controller.
// edge_count wraps at the latched prescale; bit_cnt advances on FSM request.
module edge_bit_counter #(
    parameter int PRESCALE_WIDTH = 5,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic                      bit_clear_i,
    input  logic                      bit_inc_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic [PRESCALE_WIDTH-1:0] edge_count_o,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o,
    output logic                      bit_end_o
);

    logic [PRESCALE_WIDTH-1:0] edge_count_q, edge_count_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;

    assign bit_end_o    = enable_i && (edge_count_q == prescale_i);
    assign edge_count_o = edge_count_q;
    assign bit_cnt_o    = bit_cnt_q;

    always_comb begin
        edge_count_d = edge_count_q;
        bit_cnt_d    = bit_cnt_q;
        if (clear_i) begin
            edge_count_d = '0;
        end else if (enable_i) begin
            edge_count_d = bit_end_o ? '0 : edge_count_q + 1'b1;
        end
        if (clear_i || bit_clear_i) begin
            bit_cnt_d = '0;
        end else if (bit_inc_i) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_count_q <= '0;
            bit_cnt_q    <= '0;
        end else begin
            edge_count_q <= edge_count_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserialization,
// parity and stop checking, and one-cycle result strobes.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic                      sampled_bit,
    output logic                      sample_en,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      frame_err_q, frame_err_d;
    logic                      data_valid_q, data_valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;
    logic                      bit_inc;
    logic                      bit_end;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;

    edge_bit_counter #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH),
        .BIT_CNT_WIDTH (BIT_CNT_WIDTH)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (state_q != IDLE),
        .clear_i     (state_q == IDLE),
        .bit_clear_i (state_q == START),
        .bit_inc_i   (bit_inc),
        .prescale_i  (prescale_q),
        .edge_count_o(edge_count),
        .bit_cnt_o   (bit_cnt),
        .bit_end_o   (bit_end)
    );

    assign sample_en  = (state_q != IDLE);
    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        bit_inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d     = START;
                    prescale_d  = prescale;
                    frame_err_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    bit_inc = 1'b1;
                    if (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        state_d = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    if (sampled_bit != parity_bit(^shift_q, par_typ)) begin
                        frame_err_d = 1'b1;
                        par_err_d   = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!sampled_bit) begin
                        stp_err_d = 1'b1;
                    end else if (!frame_err_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    // A low line at the stop bit end is the next start bit: no idle gap needed.
                    if (!rx_in) begin
                        state_d     = START;
                        prescale_d  = prescale;
                        frame_err_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prescale_q   <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            frame_err_q  <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            frame_err_q  <= frame_err_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

endmodule
